imem_sync: RTL and testbench
============================

# imem_sync

Synchronous-read, parametrised instruction memory for the fetch stage of the core. It replaces the purely combinational instruction store with a clocked read pipeline of configurable latency, with a request/valid handshake, fetch stall and redirect flush. Misaligned and out-of-range fetches are reported as errors. It also provides a write port for preloading the program before the core is released.

## Interface
- SIZE_IN_WORDS, 1024: depth in 32-bit words; power of two, ≥ 2.
- READ_LATENCY, 1: cycles from accepted request to response; legal range 1..4.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0; word-aligned.
- ip_clk  in  1  sole clock; all state changes on the rising edge.
- ip_reset  in  1  asynchronous, active-high reset.
- ip_inst_req  in  1  fetch request.
- ip_inst_addr  in  32  byte address of the fetch.
- op_inst_ready  out  1  request accepted this cycle when high together with ip_inst_req.
- ip_inst_stall  in  1  consumer cannot take a response; freezes the read pipeline.
- ip_flush  in  1  redirect; discards all in-flight responses.
- op_inst_valid  out  1  response present.
- op_inst_from_imem  out  32  instruction word.
- op_inst_error  out  1  response is for a misaligned or out-of-range address.
- ip_load_en  in  1  preload write strobe.
- ip_load_addr  in  32  byte address of the preload write.
- ip_load_data  in  32  preload word.

## Operation
- Index: idx = (addr − BASE_ADDR) >> 2, evaluated on clog2(SIZE_IN_WORDS) bits after an unsigned range check.
- Error conditions: addr[1:0] ≠ 0, addr < BASE_ADDR, or idx ≥ SIZE_IN_WORDS.
- On an error, the response carries op_inst_error=1 and data 32'h0000_0013 (NOP), and no array read is performed.
- op_inst_ready = !ip_reset && !ip_load_en && !ip_inst_stall.
- The acceptance cycle is ip_inst_req && op_inst_ready.
- Each accepted request enters a READ_LATENCY-deep pipeline of {valid, error, data}. Stage 1 samples the array, and the last stage drives the outputs.
- Stall: while ip_inst_stall=1, every stage holds. Outputs stay bit-stable and nothing is lost or duplicated.
- Flush: ip_flush=1 clears every valid bit at the next edge. Flush overrides stall.
- A request presented in the same cycle as ip_flush is still accepted and is the only survivor.
- Preload: when ip_load_en=1, mem[idx(ip_load_addr)] ← ip_load_data at the edge. Out-of-range or misaligned load writes are dropped silently.
- Load and fetch are never accepted in the same cycle, because ready is low during a load.
- A fetch accepted after the load edge returns the new word.
- Memory contents are not reset. Only pipeline state is reset.

## Timing
- Reset values: op_inst_valid=0, op_inst_error=0, op_inst_from_imem=32'h0, all stage valid bits 0. op_inst_ready is 0 while ip_reset is asserted.
- Latency: a request accepted at edge N yields op_inst_valid=1 after edge N+READ_LATENCY, assuming no stall cycles in between.
- Each stall cycle adds exactly one cycle.
- Throughput: one request per cycle while unstalled. Responses are in order.
- Reset mid-operation: in-flight responses are discarded asynchronously. Preload data already written is retained.
- Stall and flush together: the pipeline empties. A simultaneous request is not accepted, because ready is low under stall.
- ip_flush with an empty pipeline: no effect.
- The address arithmetic is 32-bit unsigned. The underflow at addr < BASE_ADDR is detected before the subtraction result is used.

## Structure
- Shared package imem_pkg holds:
  - IMEM_NOP = 32'h0000_0013;
  - IMEM_MAX_LATENCY = 4;
  - the response struct {valid, error, data}.
- Parameter check: READ_LATENCY outside 1..4 or a non-power-of-two SIZE_IN_WORDS is a fatal elaboration error.
- Sub-module imem_lat_pipe holds the parametrised stall/flush-aware response pipeline, with stage count = READ_LATENCY − 1 after the array register.
- The top level holds the array, the index/range logic and the load port.

## Test plan
- Basic read: preload mem[0..3] = 11,22,33,44; READ_LATENCY=2; fetch 0x0,0x4,0x8 back-to-back → valid for 3 consecutive cycles starting 2 cycles after the first acceptance, data 11,22,33, error=0.
- Errors: fetch 0x2, then fetch BASE_ADDR+4·SIZE_IN_WORDS → two responses with error=1, data 32'h13.
- Stall: stall for 3 cycles while a response is valid → outputs unchanged for all 3 cycles and ready=0; after release the order and count are preserved.
- Flush: flush with 3 requests in flight plus a same-cycle request to 0xC → only 44 emerges, READ_LATENCY cycles later.
- Load/fetch ordering: load mem[1]=0xDEAD in cycle N while requesting 0x4 → request not accepted in N; the re-request in N+1 returns 0xDEAD.
- Reset: assert ip_reset asynchronously with 2 responses in flight → valid drops immediately; after deassert no stale response appears; preloaded data is intact.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and response type for the instruction memory
//
// Purpose: NOP fill word, latency ceiling, pipeline response struct and a
// power-of-two helper used by the elaboration-time parameter check.

package imem_pkg;

  localparam logic [31:0] IMEM_NOP         = 32'h0000_0013;
  localparam int          IMEM_MAX_LATENCY = 4;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [31:0] data;
  } imem_resp_t;

  function automatic bit imem_is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/imem_sync_if.sv
// rtl/imem_sync_if.sv - fetch, response and preload signals of the instruction memory
//
// Purpose: bundles the fetch request/ready, stall/flush, response and preload
// port. master = fetch stage / loader side, slave = the memory.

interface imem_sync_if;

  logic        ip_inst_req;
  logic [31:0] ip_inst_addr;
  logic        op_inst_ready;
  logic        ip_inst_stall;
  logic        ip_flush;
  logic        op_inst_valid;
  logic [31:0] op_inst_from_imem;
  logic        op_inst_error;
  logic        ip_load_en;
  logic [31:0] ip_load_addr;
  logic [31:0] ip_load_data;

  modport master (
    output ip_inst_req, ip_inst_addr, ip_inst_stall, ip_flush,
           ip_load_en, ip_load_addr, ip_load_data,
    input  op_inst_ready, op_inst_valid, op_inst_from_imem, op_inst_error
  );

  modport slave (
    input  ip_inst_req, ip_inst_addr, ip_inst_stall, ip_flush,
           ip_load_en, ip_load_addr, ip_load_data,
    output op_inst_ready, op_inst_valid, op_inst_from_imem, op_inst_error
  );

endinterface

// File: rtl/imem_lat_pipe.sv
// rtl/imem_lat_pipe.sv - stall/flush-aware response delay line
//
// Purpose: delays the array-register response by STAGES cycles.
// Ports:
//   ip_clk, ip_reset : clock, asynchronous active-high reset
//   ip_stall         : hold every stage
//   ip_flush         : clear every valid bit (wins over stall)
//   ip_resp          : response from the array register
//   op_resp          : response of the last stage

module imem_lat_pipe
  import imem_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic       ip_clk,
  input  logic       ip_reset,
  input  logic       ip_stall,
  input  logic       ip_flush,
  input  imem_resp_t ip_resp,
  output imem_resp_t op_resp
);

  if (STAGES == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{ip_clk, ip_reset, ip_stall, ip_flush};
    assign op_resp   = ip_resp;
  end else begin : g_stages
    imem_resp_t stage_q [STAGES];
    imem_resp_t stage_d [STAGES];
    // chain[i] feeds stage i; chain[STAGES] is the last stage
    imem_resp_t chain   [STAGES+1];

    assign chain[0] = ip_resp;
    for (genvar g = 1; g <= STAGES; g++) begin : g_chain
      assign chain[g] = stage_q[g-1];
    end
    assign op_resp = chain[STAGES];

    always_comb begin
      for (int i = 0; i < STAGES; i++) begin
        stage_d[i] = stage_q[i];
        if (!ip_stall) stage_d[i] = chain[i];
        if (ip_flush)  stage_d[i].valid = 1'b0;
      end
    end

    always_ff @(posedge ip_clk or posedge ip_reset) begin
      if (ip_reset) begin
        for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
        for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
      end
    end
  end

endmodule

// File: rtl/imem_sync.sv
// rtl/imem_sync.sv - synchronous-read instruction memory with preload port
//
// Purpose: word array with a clocked read pipeline of READ_LATENCY cycles,
// range/alignment error reporting, stall hold, redirect flush and preload.
// Ports:
//   ip_clk, ip_reset : clock, asynchronous active-high reset
//   bus (slave)      : fetch request/ready, stall, flush, response, preload

module imem_sync
  import imem_pkg::*;
#(
  parameter int          SIZE_IN_WORDS = 1024,
  parameter int          READ_LATENCY  = 1,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000
) (
  input  logic        ip_clk,
  input  logic        ip_reset,
  imem_sync_if.slave  bus
);

  localparam int          IDX_W  = $clog2(SIZE_IN_WORDS);
  localparam logic [31:0] SIZE_W = 32'(SIZE_IN_WORDS);

  if (READ_LATENCY < 1 || READ_LATENCY > IMEM_MAX_LATENCY ||
      !imem_is_pow2(SIZE_IN_WORDS) || BASE_ADDR[1:0] != 2'b00) begin : g_param_check
    $fatal(1, "imem_sync: illegal READ_LATENCY, SIZE_IN_WORDS or BASE_ADDR");
  end

  // Misalignment is tested on the offset: BASE_ADDR is word aligned, so the
  // low bits match the address. Underflow is caught by the direct compare,
  // so a wrapped offset never reaches the index.
  function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] off);
    return (off[1:0] != 2'b00) || (addr < BASE_ADDR) || ({2'b00, off[31:2]} >= SIZE_W);
  endfunction

  logic [31:0] mem_q [SIZE_IN_WORDS];

  logic [31:0]      fetch_off, load_off;
  logic             fetch_err, load_err;
  logic [IDX_W-1:0] fetch_idx, load_idx;
  logic             ready, accept;
  imem_resp_t       s1_q, s1_d, pipe_out;

  always_comb begin
    fetch_off = bus.ip_inst_addr - BASE_ADDR;
    load_off  = bus.ip_load_addr - BASE_ADDR;
    fetch_err = addr_bad(bus.ip_inst_addr, fetch_off);
    load_err  = addr_bad(bus.ip_load_addr, load_off);
    fetch_idx = fetch_off[IDX_W+1:2];
    load_idx  = load_off[IDX_W+1:2];
    ready     = !ip_reset && !bus.ip_load_en && !bus.ip_inst_stall;
    accept    = bus.ip_inst_req && ready;

    // Stage 1: the array register. Accept implies no stall, so a request
    // arriving with a flush lands here as the only surviving entry.
    s1_d = s1_q;
    if (accept) begin
      s1_d.valid = 1'b1;
      s1_d.error = fetch_err;
      s1_d.data  = fetch_err ? IMEM_NOP : mem_q[fetch_idx];
    end else if (bus.ip_flush || !bus.ip_inst_stall) begin
      s1_d.valid = 1'b0;
    end
  end

  always_ff @(posedge ip_clk or posedge ip_reset) begin
    if (ip_reset) s1_q <= '0;
    else          s1_q <= s1_d;
  end

  // Contents survive reset so a preloaded program outlives a core reset.
  always_ff @(posedge ip_clk) begin
    if (bus.ip_load_en && !load_err) mem_q[load_idx] <= bus.ip_load_data;
  end

  imem_lat_pipe #(.STAGES(READ_LATENCY - 1)) u_pipe (
    .ip_clk   (ip_clk),
    .ip_reset (ip_reset),
    .ip_stall (bus.ip_inst_stall),
    .ip_flush (bus.ip_flush),
    .ip_resp  (s1_q),
    .op_resp  (pipe_out)
  );

  assign bus.op_inst_ready     = ready;
  assign bus.op_inst_valid     = pipe_out.valid;
  assign bus.op_inst_error     = pipe_out.error;
  assign bus.op_inst_from_imem = pipe_out.data;

endmodule

// File: tb/tb_imem_sync.sv
// tb/tb_imem_sync.sv - directed scoreboard bench for imem_sync

module tb_imem_sync;
  import imem_pkg::*;

  localparam int          SIZE = 16;
  localparam int          RL   = 2;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_sync_if bus();

  imem_sync #(.SIZE_IN_WORDS(SIZE), .READ_LATENCY(RL), .BASE_ADDR(BASE)) dut (
    .ip_clk   (clk),
    .ip_reset (rst),
    .bus      (bus)
  );

  typedef struct packed {
    logic        error;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic e, input logic [31:0] d);
    bus.ip_inst_req  = 1'b1;
    bus.ip_inst_addr = a;
    sb.push_back({e, d});
  endtask

  task automatic idle();
    bus.ip_inst_req = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.ip_load_en   = 1'b1;
    bus.ip_load_addr = a;
    bus.ip_load_data = d;
    step();
    bus.ip_load_en   = 1'b0;
  endtask

  // A response is consumed at the edge following a negedge where it is
  // valid, unstalled and not being flushed.
  always @(negedge clk) begin
    if (bus.op_inst_valid && !bus.ip_inst_stall && !bus.ip_flush) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {31'b0, bus.op_inst_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_data", bus.op_inst_from_imem, mon_e.data);
        chk("resp_err", {31'b0, bus.op_inst_error}, {31'b0, mon_e.error});
      end
    end
  end

  initial begin
    bus.ip_inst_req   = 1'b0;
    bus.ip_inst_addr  = '0;
    bus.ip_inst_stall = 1'b0;
    bus.ip_flush      = 1'b0;
    bus.ip_load_en    = 1'b0;
    bus.ip_load_addr  = '0;
    bus.ip_load_data  = '0;

    #2;
    chk("rst_valid", {31'b0, bus.op_inst_valid}, 32'd0);
    chk("rst_error", {31'b0, bus.op_inst_error}, 32'd0);
    chk("rst_data", bus.op_inst_from_imem, 32'd0);
    chk("rst_ready", {31'b0, bus.op_inst_ready}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("ready_idle", {31'b0, bus.op_inst_ready}, 32'd1);

    // preload; ready drops while loading
    bus.ip_load_en   = 1'b1;
    bus.ip_load_addr = BASE;
    bus.ip_load_data = 32'd11;
    #1;
    chk("ready_load", {31'b0, bus.op_inst_ready}, 32'd0);
    step();
    bus.ip_load_en = 1'b0;
    load(BASE + 32'd4,  32'd22);
    load(BASE + 32'd8,  32'd33);
    load(BASE + 32'd12, 32'd44);

    // basic back-to-back read with latency check
    fetch(BASE, 1'b0, 32'd11);
    step();
    chk("lat_early", {31'b0, bus.op_inst_valid}, 32'd0);
    fetch(BASE + 32'd4, 1'b0, 32'd22);
    step();
    chk("lat_first", {31'b0, bus.op_inst_valid}, 32'd1);
    fetch(BASE + 32'd8, 1'b0, 32'd33);
    step();
    chk("stream_v1", {31'b0, bus.op_inst_valid}, 32'd1);
    idle();
    step();
    chk("stream_v2", {31'b0, bus.op_inst_valid}, 32'd1);
    step();
    chk("stream_end", {31'b0, bus.op_inst_valid}, 32'd0);

    // misaligned, past end, below base
    fetch(BASE + 32'd2, 1'b1, IMEM_NOP);
    step();
    fetch(BASE + 32'(4 * SIZE), 1'b1, IMEM_NOP);
    step();
    fetch(BASE - 32'd4, 1'b1, IMEM_NOP);
    step();
    idle();
    repeat (3) step();

    // bad preload writes are dropped, word 0 unchanged
    load(BASE + 32'(4 * SIZE), 32'hBAD0_BAD0);
    load(BASE + 32'd1, 32'hBAD1_BAD1);
    fetch(BASE, 1'b0, 32'd11);
    step();
    idle();
    repeat (3) step();

    // stall with a valid response held on the outputs
    fetch(BASE, 1'b0, 32'd11);
    step();
    fetch(BASE + 32'd4, 1'b0, 32'd22);
    step();
    idle();
    bus.ip_inst_stall = 1'b1;
    #1;
    chk("stall_ready", {31'b0, bus.op_inst_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {31'b0, bus.op_inst_valid}, 32'd1);
      chk("stall_data", bus.op_inst_from_imem, 32'd11);
      chk("stall_ready", {31'b0, bus.op_inst_ready}, 32'd0);
    end
    bus.ip_inst_stall = 1'b0;
    repeat (4) step();

    // flush with requests in flight plus a same-cycle request
    fetch(BASE, 1'b0, 32'd11);
    step();
    fetch(BASE + 32'd4, 1'b0, 32'd22);
    step();
    fetch(BASE + 32'd8, 1'b0, 32'd33);
    step();
    bus.ip_flush = 1'b1;
    sb.delete();
    fetch(BASE + 32'd12, 1'b0, 32'd44);
    step();
    bus.ip_flush = 1'b0;
    idle();
    chk("flush_gap", {31'b0, bus.op_inst_valid}, 32'd0);
    step();
    chk("flush_surv_v", {31'b0, bus.op_inst_valid}, 32'd1);
    chk("flush_surv_d", bus.op_inst_from_imem, 32'd44);
    step();
    chk("flush_after", {31'b0, bus.op_inst_valid}, 32'd0);
    repeat (2) step();

    // load and fetch in the same cycle: fetch waits one cycle
    bus.ip_load_en   = 1'b1;
    bus.ip_load_addr = BASE + 32'd4;
    bus.ip_load_data = 32'h0000_DEAD;
    bus.ip_inst_req  = 1'b1;
    bus.ip_inst_addr = BASE + 32'd4;
    #1;
    chk("ld_fetch_ready", {31'b0, bus.op_inst_ready}, 32'd0);
    step();
    bus.ip_load_en = 1'b0;
    sb.push_back({1'b0, 32'h0000_DEAD});
    step();
    idle();
    chk("ld_not_taken", {31'b0, bus.op_inst_valid}, 32'd0);
    step();
    chk("ld_new_v", {31'b0, bus.op_inst_valid}, 32'd1);
    chk("ld_new_d", bus.op_inst_from_imem, 32'h0000_DEAD);
    repeat (3) step();

    // asynchronous reset with two responses in flight
    fetch(BASE + 32'd8, 1'b0, 32'd33);
    step();
    fetch(BASE + 32'd12, 1'b0, 32'd44);
    step();
    idle();
    chk("pre_rst_valid", {31'b0, bus.op_inst_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, bus.op_inst_valid}, 32'd0);
    chk("async_rst_ready", {31'b0, bus.op_inst_ready}, 32'd0);
    sb.delete();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale", {31'b0, bus.op_inst_valid}, 32'd0);
    end
    fetch(BASE + 32'd4, 1'b0, 32'h0000_DEAD);
    step();
    fetch(BASE + 32'd12, 1'b0, 32'd44);
    step();
    idle();
    repeat (4) step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
